dma64_mem_responder: RTL and testbench

//  Target-side counterpart of the accelerator 64-bit DMA interface (ctrl/chnl valid-ready).

---
 rtl/dma64_mem_responder.sv | 134 +++++++++++++
 tb/tb_dma64_mem_responder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma64_mem_responder.sv
// DMA target endpoint: serves 64-bit read/write ctrl requests from a local word memory.
// One transaction at a time; reads stream at 1 beat per 2 cycles, writes sink 1 beat per cycle.
module dma64_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int SIZE_OK = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dma_read_ctrl_valid,
    output logic              dma_read_ctrl_ready,
    input  logic [31:0]       dma_read_ctrl_data_index,
    input  logic [31:0]       dma_read_ctrl_data_length,
    input  logic [2:0]        dma_read_ctrl_data_size,
    output logic              dma_read_chnl_valid,
    input  logic              dma_read_chnl_ready,
    output logic [63:0]       dma_read_chnl_data,
    input  logic              dma_write_ctrl_valid,
    output logic              dma_write_ctrl_ready,
    input  logic [31:0]       dma_write_ctrl_data_index,
    input  logic [31:0]       dma_write_ctrl_data_length,
    input  logic [2:0]        dma_write_ctrl_data_size,
    input  logic              dma_write_chnl_valid,
    output logic              dma_write_chnl_ready,
    input  logic [63:0]       dma_write_chnl_data,
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [63:0]       bd_wdata,
    output logic [63:0]       bd_rdata,
    output logic              busy,
    output logic [1:0]        err
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, RD_FETCH, RD_SEND, WR_RECV} state_t;

    state_t            state, state_nxt;
    logic [63:0]       mem [DEPTH];
    logic [63:0]       rd_beat_p1;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       rem;
    logic              rr;
    logic              rd_acc, wr_acc, ctrl_acc;
    logic              rd_fire, wr_fire, mem_we;
    logic [31:0]       acc_index, acc_length;
    logic [2:0]        acc_size;
    logic [32:0]       acc_end;

    assign rd_acc     = dma_read_ctrl_valid & dma_read_ctrl_ready;
    assign wr_acc     = dma_write_ctrl_valid & dma_write_ctrl_ready;
    assign ctrl_acc   = rd_acc | wr_acc;
    assign rd_fire    = dma_read_chnl_valid & dma_read_chnl_ready;
    assign wr_fire    = dma_write_chnl_valid & dma_write_chnl_ready;
    assign acc_index  = rd_acc ? dma_read_ctrl_data_index  : dma_write_ctrl_data_index;
    assign acc_length = rd_acc ? dma_read_ctrl_data_length : dma_write_ctrl_data_length;
    assign acc_size   = rd_acc ? dma_read_ctrl_data_size   : dma_write_ctrl_data_size;
    assign acc_end    = {1'b0, acc_index} + {1'b0, acc_length};
    // A beat presented in the reset cycle belongs to the aborted transaction.
    assign mem_we     = wr_fire & ~rst;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ctrl_acc && acc_length != 32'd0)
                    state_nxt = rd_acc ? RD_FETCH : WR_RECV;
            end
            RD_FETCH: state_nxt = RD_SEND;
            RD_SEND: begin
                if (rd_fire) state_nxt = (rem == 32'd1) ? IDLE : RD_FETCH;
            end
            WR_RECV: begin
                if (wr_fire && rem == 32'd1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Round-robin grant: rr = 1 means the read side won the last accept.
    always_comb begin
        dma_read_ctrl_ready  = 1'b0;
        dma_write_ctrl_ready = 1'b0;
        if (state == IDLE) begin
            if (dma_read_ctrl_valid && (!dma_write_ctrl_valid || !rr))
                dma_read_ctrl_ready = 1'b1;
            else if (dma_write_ctrl_valid)
                dma_write_ctrl_ready = 1'b1;
        end
        dma_read_chnl_valid  = (state == RD_SEND);
        dma_write_chnl_ready = (state == WR_RECV);
        busy                 = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr   <= 1'b0;
            err  <= 2'b00;
            addr <= '0;
            rem  <= '0;
        end else if (ctrl_acc) begin
            rr   <= rd_acc;
            addr <= acc_index[ADDR_W-1:0];
            rem  <= acc_length;
            err  <= err | {acc_end > 33'(DEPTH), acc_size != 3'(SIZE_OK)};
        end else if (rd_fire || wr_fire) begin
            addr <= addr + ADDR_W'(1);
            rem  <= rem - 32'd1;
        end
    end

    // DMA write takes priority over a backdoor write to the same word.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr] <= dma_write_chnl_data;
        if (bd_we && !(mem_we && bd_addr == addr)) mem[bd_addr] <= bd_wdata;
    end

    // Fetch stage: beat is held in rd_beat_p1 until the channel handshake.
    always_ff @(posedge clk) begin
        if (state == RD_FETCH) rd_beat_p1 <= mem[addr];
    end

    assign dma_read_chnl_data = rd_beat_p1;

    always_ff @(posedge clk) begin
        if (rst) bd_rdata <= '0;
        else     bd_rdata <= mem[bd_addr];
    end

endmodule

// File: tb/tb_dma64_mem_responder.sv
// Directed bench for dma64_mem_responder: read/write streaming, arbitration, stalls, wrap, reset abort.
module tb_dma64_mem_responder;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              dma_read_ctrl_valid;
    logic              dma_read_ctrl_ready;
    logic [31:0]       dma_read_ctrl_data_index;
    logic [31:0]       dma_read_ctrl_data_length;
    logic [2:0]        dma_read_ctrl_data_size;
    logic              dma_read_chnl_valid;
    logic              dma_read_chnl_ready;
    logic [63:0]       dma_read_chnl_data;
    logic              dma_write_ctrl_valid;
    logic              dma_write_ctrl_ready;
    logic [31:0]       dma_write_ctrl_data_index;
    logic [31:0]       dma_write_ctrl_data_length;
    logic [2:0]        dma_write_ctrl_data_size;
    logic              dma_write_chnl_valid;
    logic              dma_write_chnl_ready;
    logic [63:0]       dma_write_chnl_data;
    logic              bd_we;
    logic [ADDR_W-1:0] bd_addr;
    logic [63:0]       bd_wdata;
    logic [63:0]       bd_rdata;
    logic              busy;
    logic [1:0]        err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] rd_beats [$];
    logic [63:0] wr_q [$];
    logic        timed_out;
    int          first_lat;
    logic [63:0] rdv;

    dma64_mem_responder #(.ADDR_W(ADDR_W), .SIZE_OK(3)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .dma_read_ctrl_valid        (dma_read_ctrl_valid),
        .dma_read_ctrl_ready        (dma_read_ctrl_ready),
        .dma_read_ctrl_data_index   (dma_read_ctrl_data_index),
        .dma_read_ctrl_data_length  (dma_read_ctrl_data_length),
        .dma_read_ctrl_data_size    (dma_read_ctrl_data_size),
        .dma_read_chnl_valid        (dma_read_chnl_valid),
        .dma_read_chnl_ready        (dma_read_chnl_ready),
        .dma_read_chnl_data         (dma_read_chnl_data),
        .dma_write_ctrl_valid       (dma_write_ctrl_valid),
        .dma_write_ctrl_ready       (dma_write_ctrl_ready),
        .dma_write_ctrl_data_index  (dma_write_ctrl_data_index),
        .dma_write_ctrl_data_length (dma_write_ctrl_data_length),
        .dma_write_ctrl_data_size   (dma_write_ctrl_data_size),
        .dma_write_chnl_valid       (dma_write_chnl_valid),
        .dma_write_chnl_ready       (dma_write_chnl_ready),
        .dma_write_chnl_data        (dma_write_chnl_data),
        .bd_we                      (bd_we),
        .bd_addr                    (bd_addr),
        .bd_wdata                   (bd_wdata),
        .bd_rdata                   (bd_rdata),
        .busy                       (busy),
        .err                        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input logic [ADDR_W-1:0] a, input logic [63:0] d);
        bd_we = 1'b1; bd_addr = a; bd_wdata = d;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic bd_read(input logic [ADDR_W-1:0] a, output logic [63:0] d);
        bd_addr = a;
        tick();
        d = bd_rdata;
    endtask

    task automatic do_read(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] size);
        int n;
        rd_beats.delete();
        timed_out = 1'b0;
        first_lat = -1;
        dma_read_chnl_ready = 1'b1;
        dma_read_ctrl_valid = 1'b1;
        dma_read_ctrl_data_index = idx;
        dma_read_ctrl_data_length = len;
        dma_read_ctrl_data_size = size;
        #1;
        n = 0;
        while (!dma_read_ctrl_ready && n < 50) begin tick(); n++; end
        if (!dma_read_ctrl_ready) begin
            timed_out = 1'b1;
            dma_read_ctrl_valid = 1'b0;
        end else begin
            tick();
            dma_read_ctrl_valid = 1'b0;
            #1;
            n = 1;
            while (rd_beats.size() < int'(len) && n < 200) begin
                if (dma_read_chnl_valid) begin
                    if (first_lat < 0) first_lat = n;
                    rd_beats.push_back(dma_read_chnl_data);
                end
                tick();
                n++;
            end
            if (rd_beats.size() < int'(len)) timed_out = 1'b1;
        end
    endtask

    task automatic do_write(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] size,
                            input int n_send);
        int n;
        int i;
        timed_out = 1'b0;
        dma_write_ctrl_valid = 1'b1;
        dma_write_ctrl_data_index = idx;
        dma_write_ctrl_data_length = len;
        dma_write_ctrl_data_size = size;
        #1;
        n = 0;
        while (!dma_write_ctrl_ready && n < 50) begin tick(); n++; end
        if (!dma_write_ctrl_ready) begin
            timed_out = 1'b1;
            dma_write_ctrl_valid = 1'b0;
        end else begin
            tick();
            dma_write_ctrl_valid = 1'b0;
            i = 0;
            n = 0;
            while (i < n_send && n < 200) begin
                dma_write_chnl_valid = 1'b1;
                dma_write_chnl_data = wr_q[i];
                #1;
                if (dma_write_chnl_ready) i++;
                tick();
                n++;
            end
            dma_write_chnl_valid = 1'b0;
            if (i < n_send) timed_out = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++; if (dma_read_ctrl_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rd_ctrl_ready got %b want 0", dma_read_ctrl_ready); end
        n_checks++; if (dma_write_ctrl_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ctrl_ready got %b want 0", dma_write_ctrl_ready); end
        n_checks++; if (dma_read_chnl_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_chnl_valid got %b want 0", dma_read_chnl_valid); end
        n_checks++; if (dma_write_chnl_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_chnl_ready got %b want 0", dma_write_chnl_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (err !== 2'b00) begin n_fail++; $display("FAIL reset_err got %b want 00", err); end
        n_checks++; if (bd_rdata !== 64'd0) begin n_fail++; $display("FAIL reset_bd_rdata got %h want 0", bd_rdata); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read_stream();
        logic [63:0] exp [4] = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
        for (int k = 0; k < 4; k++) bd_write(ADDR_W'(4 + k), exp[k]);
        do_read(32'd4, 32'd4, 3'd3);
        n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL rd_stream_timeout got %0d beats want 4", rd_beats.size()); end
        n_checks++; if (first_lat !== 2) begin n_fail++; $display("FAIL rd_stream_first_latency got %0d want 2", first_lat); end
        for (int k = 0; k < 4; k++) begin
            rdv = (k < rd_beats.size()) ? rd_beats[k] : 64'hx;
            n_checks++; if (rdv !== exp[k]) begin n_fail++; $display("FAIL rd_stream_beat%0d got %h want %h", k, rdv, exp[k]); end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_stream_busy_after got %b want 0", busy); end
        n_checks++; if (err !== 2'b00) begin n_fail++; $display("FAIL rd_stream_err got %b want 00", err); end
    endtask

    task automatic test_write_readback();
        wr_q = '{64'd1, 64'd2, 64'd3};
        do_write(32'd10, 32'd3, 3'd3, 3);
        n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL wr_timeout got 1 want 0"); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_after got %b want 0", busy); end
        n_checks++; if (dma_write_chnl_ready !== 1'b0) begin n_fail++; $display("FAIL wr_chnl_ready_after got %b want 0", dma_write_chnl_ready); end
        for (int k = 0; k < 3; k++) begin
            bd_read(ADDR_W'(10 + k), rdv);
            n_checks++; if (rdv !== 64'(k + 1)) begin n_fail++; $display("FAIL wr_mem%0d got %h want %h", 10 + k, rdv, k + 1); end
        end
        do_read(32'd10, 32'd3, 3'd3);
        for (int k = 0; k < 3; k++) begin
            rdv = (k < rd_beats.size()) ? rd_beats[k] : 64'hx;
            n_checks++; if (rdv !== 64'(k + 1)) begin n_fail++; $display("FAIL wr_readback%0d got %h want %h", k, rdv, k + 1); end
        end
    endtask

    task automatic test_arbitration();
        rst = 1'b1; tick(); rst = 1'b0;
        dma_read_ctrl_data_index = 32'd20;  dma_read_ctrl_data_length = 32'd0;  dma_read_ctrl_data_size = 3'd3;
        dma_write_ctrl_data_index = 32'd30; dma_write_ctrl_data_length = 32'd0; dma_write_ctrl_data_size = 3'd3;
        dma_read_ctrl_valid = 1'b1; dma_write_ctrl_valid = 1'b1;
        for (int r = 0; r < 2; r++) begin
            #1;
            n_checks++; if ({dma_read_ctrl_ready, dma_write_ctrl_ready} !== 2'b10) begin n_fail++; $display("FAIL arb_round%0d_read_first got %b want 10", r, {dma_read_ctrl_ready, dma_write_ctrl_ready}); end
            tick();
            n_checks++; if ({dma_read_ctrl_ready, dma_write_ctrl_ready} !== 2'b01) begin n_fail++; $display("FAIL arb_round%0d_write_second got %b want 01", r, {dma_read_ctrl_ready, dma_write_ctrl_ready}); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arb_round%0d_len0_busy got %b want 0", r, busy); end
            tick();
        end
        dma_read_ctrl_valid = 1'b0; dma_write_ctrl_valid = 1'b0;
        tick();
    endtask

    task automatic test_read_stall();
        int n;
        dma_read_chnl_ready = 1'b0;
        dma_read_ctrl_valid = 1'b1;
        dma_read_ctrl_data_index = 32'd4; dma_read_ctrl_data_length = 32'd2; dma_read_ctrl_data_size = 3'd3;
        #1;
        n_checks++; if (dma_read_ctrl_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ctrl_ready got %b want 1", dma_read_ctrl_ready); end
        tick();
        dma_read_ctrl_valid = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            n_checks++; if ({dma_read_chnl_valid, dma_read_chnl_data} !== {1'b1, 64'hA0}) begin n_fail++; $display("FAIL stall_hold%0d got %b/%h want 1/a0", k, dma_read_chnl_valid, dma_read_chnl_data); end
            tick();
        end
        dma_read_chnl_ready = 1'b1;
        #1;
        rd_beats.delete();
        n = 0;
        while (rd_beats.size() < 2 && n < 20) begin
            if (dma_read_chnl_valid) rd_beats.push_back(dma_read_chnl_data);
            tick();
            n++;
        end
        n_checks++; if (rd_beats.size() !== 2) begin n_fail++; $display("FAIL stall_beat_count got %0d want 2", rd_beats.size()); end
        rdv = (rd_beats.size() > 0) ? rd_beats[0] : 64'hx;
        n_checks++; if (rdv !== 64'hA0) begin n_fail++; $display("FAIL stall_beat0 got %h want a0", rdv); end
        rdv = (rd_beats.size() > 1) ? rd_beats[1] : 64'hx;
        n_checks++; if (rdv !== 64'hA1) begin n_fail++; $display("FAIL stall_beat1 got %h want a1", rdv); end
    endtask

    task automatic test_wrap_err();
        logic [63:0] exp [4] = '{64'hB0, 64'hB1, 64'hB2, 64'hB3};
        bd_write(ADDR_W'(DEPTH - 2), exp[0]);
        bd_write(ADDR_W'(DEPTH - 1), exp[1]);
        bd_write(ADDR_W'(0), exp[2]);
        bd_write(ADDR_W'(1), exp[3]);
        do_read(32'(DEPTH - 2), 32'd4, 3'd2);
        n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL wrap_timeout got %0d beats want 4", rd_beats.size()); end
        for (int k = 0; k < 4; k++) begin
            rdv = (k < rd_beats.size()) ? rd_beats[k] : 64'hx;
            n_checks++; if (rdv !== exp[k]) begin n_fail++; $display("FAIL wrap_beat%0d got %h want %h", k, rdv, exp[k]); end
        end
        n_checks++; if (err !== 2'b11) begin n_fail++; $display("FAIL wrap_err got %b want 11", err); end
        do_read(32'd4, 32'd1, 3'd3);
        n_checks++; if (err !== 2'b11) begin n_fail++; $display("FAIL err_sticky got %b want 11", err); end
    endtask

    task automatic test_backdoor();
        bd_write(ADDR_W'(51), 64'h1111);
        dma_write_ctrl_valid = 1'b1;
        dma_write_ctrl_data_index = 32'd50; dma_write_ctrl_data_length = 32'd1; dma_write_ctrl_data_size = 3'd3;
        tick();
        dma_write_ctrl_valid = 1'b0;
        dma_write_chnl_valid = 1'b1; dma_write_chnl_data = 64'h5A;
        bd_we = 1'b1; bd_addr = ADDR_W'(50); bd_wdata = 64'hBAD;
        tick();
        dma_write_chnl_valid = 1'b0; bd_we = 1'b0;
        bd_read(ADDR_W'(50), rdv);
        n_checks++; if (rdv !== 64'h5A) begin n_fail++; $display("FAIL bd_collision got %h want 5a", rdv); end
        bd_we = 1'b1; bd_addr = ADDR_W'(51); bd_wdata = 64'h2222;
        tick();
        bd_we = 1'b0;
        n_checks++; if (bd_rdata !== 64'h1111) begin n_fail++; $display("FAIL bd_read_during_write got %h want 1111", bd_rdata); end
        tick();
        n_checks++; if (bd_rdata !== 64'h2222) begin n_fail++; $display("FAIL bd_after_write got %h want 2222", bd_rdata); end
    endtask

    task automatic test_reset_mid_write();
        for (int k = 0; k < 5; k++) bd_write(ADDR_W'(40 + k), 64'hEE);
        wr_q = '{64'h11, 64'h22, 64'h33, 64'h44, 64'h55};
        do_write(32'd40, 32'd5, 3'd3, 2);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midwr_busy_before got %b want 1", busy); end
        rst = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midwr_busy got %b want 0", busy); end
        n_checks++; if (dma_write_chnl_ready !== 1'b0) begin n_fail++; $display("FAIL midwr_chnl_ready got %b want 0", dma_write_chnl_ready); end
        n_checks++; if ({dma_read_ctrl_ready, dma_write_ctrl_ready} !== 2'b00) begin n_fail++; $display("FAIL midwr_ctrl_ready got %b want 00", {dma_read_ctrl_ready, dma_write_ctrl_ready}); end
        n_checks++; if (err !== 2'b00) begin n_fail++; $display("FAIL midwr_err got %b want 00", err); end
        n_checks++; if (bd_rdata !== 64'd0) begin n_fail++; $display("FAIL midwr_bd_rdata got %h want 0", bd_rdata); end
        rst = 1'b0;
        bd_read(ADDR_W'(40), rdv);
        n_checks++; if (rdv !== 64'h11) begin n_fail++; $display("FAIL midwr_mem40 got %h want 11", rdv); end
        bd_read(ADDR_W'(41), rdv);
        n_checks++; if (rdv !== 64'h22) begin n_fail++; $display("FAIL midwr_mem41 got %h want 22", rdv); end
        bd_read(ADDR_W'(42), rdv);
        n_checks++; if (rdv !== 64'hEE) begin n_fail++; $display("FAIL midwr_mem42 got %h want ee", rdv); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        dma_read_ctrl_valid = 1'b0; dma_read_ctrl_data_index = '0; dma_read_ctrl_data_length = '0; dma_read_ctrl_data_size = '0;
        dma_read_chnl_ready = 1'b0;
        dma_write_ctrl_valid = 1'b0; dma_write_ctrl_data_index = '0; dma_write_ctrl_data_length = '0; dma_write_ctrl_data_size = '0;
        dma_write_chnl_valid = 1'b0; dma_write_chnl_data = '0;
        bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
        test_reset();
        test_read_stream();
        test_write_readback();
        test_arbitration();
        test_read_stall();
        test_wrap_err();
        test_backdoor();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
